// File: rtl/alu_iter.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus iterative multiply and divide.
// Multiply/divide take WIDTH step cycles and return a hi/lo pair; results hold until out_ready.
module alu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] port_a,
   input  logic [WIDTH-1:0] port_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             negative,
   output logic             zero,
   output logic             overflow,
   output logic             div_zero
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0]   LAST    = SHW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   typedef enum logic [3:0] {
      OP_SLL  = 4'd0,  OP_SRL  = 4'd1,  OP_SRA   = 4'd2,  OP_ADD  = 4'd3,
      OP_SUB  = 4'd4,  OP_AND  = 4'd5,  OP_OR    = 4'd6,  OP_XOR  = 4'd7,
      OP_NOR  = 4'd8,  OP_SLT  = 4'd9,  OP_SLTU  = 4'd10, OP_MULT = 4'd11,
      OP_MULTU = 4'd12, OP_DIV = 4'd13, OP_DIVU  = 4'd14, OP_RSVD = 4'd15
   } op_t;

   state_t           state_q, state_d;
   op_t              op_in, op_q;
   logic [SHW-1:0]   count_q;
   logic [WIDTH-1:0] acc_hi_q, acc_lo_q, mag_b_q, a_q;
   logic             a_neg_q, b_neg_q, b_zero_q, div_ovf_q;
   logic [WIDTH-1:0] lo_q, hi_q;
   logic             ovf_q, dz_q;

   logic             accept, last_step;
   logic             iter_in, signed_in, a_neg_in, b_neg_in;
   logic [WIDTH-1:0] mag_a_in, mag_b_in;

   assign op_in     = op_t'(op);
   assign iter_in   = op_in inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
   assign signed_in = op_in inside {OP_MULT, OP_DIV};
   assign a_neg_in  = signed_in & port_a[WIDTH-1];
   assign b_neg_in  = signed_in & port_b[WIDTH-1];
   assign mag_a_in  = a_neg_in ? ('0 - port_a) : port_a;
   assign mag_b_in  = b_neg_in ? ('0 - port_b) : port_b;

   // Control: state register plus next-state/handshake decode.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      last_step = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = iter_in ? BUSY : DONE;
         end
         BUSY: begin
            if (count_q == LAST) begin
               last_step = 1'b1;
               state_d   = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept = in_valid & in_ready;

   // Single-cycle datapath, evaluated on the live operands at the accept edge.
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] sum, diff, sc_lo;
   logic             sc_ovf;

   assign shamt = port_b[SHW-1:0];
   assign sum   = port_a + port_b;
   assign diff  = port_a - port_b;

   always_comb begin
      sc_lo  = '0;
      sc_ovf = 1'b0;
      case (op_in)
         OP_SLL:  sc_lo = port_a << shamt;
         OP_SRL:  sc_lo = port_a >> shamt;
         OP_SRA:  sc_lo = $signed(port_a) >>> shamt;
         OP_ADD: begin
            sc_lo  = sum;
            sc_ovf = (port_a[WIDTH-1] == port_b[WIDTH-1]) && (sum[WIDTH-1] != port_a[WIDTH-1]);
         end
         OP_SUB: begin
            sc_lo  = diff;
            sc_ovf = (port_a[WIDTH-1] != port_b[WIDTH-1]) && (diff[WIDTH-1] != port_a[WIDTH-1]);
         end
         OP_AND:  sc_lo = port_a & port_b;
         OP_OR:   sc_lo = port_a | port_b;
         OP_XOR:  sc_lo = port_a ^ port_b;
         OP_NOR:  sc_lo = ~(port_a | port_b);
         OP_SLT:  sc_lo = {{(WIDTH-1){1'b0}}, $signed(port_a) < $signed(port_b)};
         OP_SLTU: sc_lo = {{(WIDTH-1){1'b0}}, port_a < port_b};
         default: sc_lo = '0;
      endcase
   end

   // One iteration step. Both algorithms share {acc_hi, acc_lo}: product or remainder/quotient.
   logic             is_mul_q;
   logic [WIDTH-1:0] mul_addend, mul_hi_n, mul_lo_n;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_sub, div_hi_n, div_lo_n;
   logic [WIDTH-1:0] step_hi, step_lo;

   assign is_mul_q   = op_q inside {OP_MULT, OP_MULTU};
   assign mul_addend = acc_lo_q[0] ? mag_b_q : '0;
   assign mul_sum    = {1'b0, acc_hi_q} + {1'b0, mul_addend};
   assign mul_hi_n   = mul_sum[WIDTH:1];
   assign mul_lo_n   = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

   assign div_shift  = {acc_hi_q, acc_lo_q[WIDTH-1]};
   assign div_ge     = div_shift >= {1'b0, mag_b_q};
   assign div_sub    = div_shift[WIDTH-1:0] - mag_b_q;
   assign div_hi_n   = div_ge ? div_sub : div_shift[WIDTH-1:0];
   assign div_lo_n   = {acc_lo_q[WIDTH-2:0], div_ge};

   assign step_hi    = is_mul_q ? mul_hi_n : div_hi_n;
   assign step_lo    = is_mul_q ? mul_lo_n : div_lo_n;

   // Final-step fixups: sign restore, divide-by-zero and MIN/-1 handling.
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem, fin_lo, fin_hi;
   logic               fin_ovf, fin_dz;

   always_comb begin
      prod    = {mul_hi_n, mul_lo_n};
      quo     = div_lo_n;
      rem     = div_hi_n;
      fin_lo  = '0;
      fin_hi  = '0;
      fin_ovf = 1'b0;
      fin_dz  = 1'b0;
      if (op_q == OP_MULT && (a_neg_q ^ b_neg_q)) prod = '0 - prod;
      if (op_q == OP_DIV) begin
         if (a_neg_q ^ b_neg_q) quo = '0 - quo;
         if (a_neg_q)           rem = '0 - rem;
      end
      if (is_mul_q) begin
         fin_lo = prod[WIDTH-1:0];
         fin_hi = prod[2*WIDTH-1:WIDTH];
      end else if (b_zero_q) begin
         fin_lo = '1;
         fin_hi = a_q;
         fin_dz = 1'b1;
      end else begin
         fin_lo  = quo;
         fin_hi  = rem;
         fin_ovf = div_ovf_q;
      end
   end

   // Datapath registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         op_q      <= OP_RSVD;
         count_q   <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         mag_b_q   <= '0;
         a_q       <= '0;
         a_neg_q   <= 1'b0;
         b_neg_q   <= 1'b0;
         b_zero_q  <= 1'b0;
         div_ovf_q <= 1'b0;
         lo_q      <= '0;
         hi_q      <= '0;
         ovf_q     <= 1'b0;
         dz_q      <= 1'b0;
      end else if (accept) begin
         op_q      <= op_in;
         count_q   <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= mag_a_in;
         mag_b_q   <= mag_b_in;
         a_q       <= port_a;
         a_neg_q   <= a_neg_in;
         b_neg_q   <= b_neg_in;
         b_zero_q  <= (port_b == '0);
         div_ovf_q <= (op_in == OP_DIV) && (port_a == MIN_VAL) && (port_b == '1);
         if (!iter_in) begin
            lo_q  <= sc_lo;
            hi_q  <= '0;
            ovf_q <= sc_ovf;
            dz_q  <= 1'b0;
         end
      end else if (state_q == BUSY) begin
         count_q  <= count_q + 1'b1;
         acc_hi_q <= step_hi;
         acc_lo_q <= step_lo;
         if (last_step) begin
            lo_q  <= fin_lo;
            hi_q  <= fin_hi;
            ovf_q <= fin_ovf;
            dz_q  <= fin_dz;
         end
      end
   end

   assign result_lo = lo_q;
   assign result_hi = hi_q;
   assign overflow  = ovf_q;
   assign div_zero  = dz_q;
   assign negative  = lo_q[WIDTH-1];
   assign zero      = (lo_q == '0);

endmodule

// File: tb/tb_alu_iter.sv
// Directed, table-driven bench for alu_iter (WIDTH=32) with hand-written
// sequences for output hold, handshake release and mid-operation reset.
module tb_alu_iter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [3:0]  op;
   logic [31:0] port_a, port_b, result_lo, result_hi;
   logic        negative, zero, overflow, div_zero;

   alu_iter #(.WIDTH(32)) dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .port_a(port_a), .port_b(port_b), .out_valid(out_valid), .out_ready(out_ready),
      .result_lo(result_lo), .result_hi(result_hi), .negative(negative), .zero(zero),
      .overflow(overflow), .div_zero(div_zero)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a, b, lo, hi;
      logic        ovf, dz;
      int          lat;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int lat;
   logic rdy_bad;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Issue one op when in_ready, scramble operands after the accept edge,
   // then wait (bounded) for out_valid, measuring latency from the accept edge.
   task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      int guard = 0;
      @(negedge CLK);
      while (!in_ready && guard < 100) begin
         @(negedge CLK);
         guard++;
      end
      check("accept_ready", in_ready, 1);
      in_valid = 1'b1; op = o; port_a = a; port_b = b;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      op = 4'($urandom_range(0, 15)); port_a = $urandom; port_b = $urandom;
      rdy_bad = 1'b0;
      lat = 1;
      @(negedge CLK);
      while (!out_valid && lat < 200) begin
         if (in_ready) rdy_bad = 1'b1;
         @(negedge CLK);
         lat++;
      end
      if (in_ready) rdy_bad = 1'b1;
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge CLK); #1;
      out_ready = 1'b0;
   endtask

   vec_t vecs[22];

   initial begin
      vecs[0]  = '{"add_ovf",   4'd3,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b1, 1'b0, 1};
      vecs[1]  = '{"sra",       4'd2,  32'h80000010, 32'h00000024, 32'hF8000001, 32'h0, 1'b0, 1'b0, 1};
      vecs[2]  = '{"srl",       4'd1,  32'h80000010, 32'h00000024, 32'h08000001, 32'h0, 1'b0, 1'b0, 1};
      vecs[3]  = '{"sll31",     4'd0,  32'h00000001, 32'h0000001F, 32'h80000000, 32'h0, 1'b0, 1'b0, 1};
      vecs[4]  = '{"sub_ovf",   4'd4,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b1, 1'b0, 1};
      vecs[5]  = '{"sub_neg",   4'd4,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h0, 1'b0, 1'b0, 1};
      vecs[6]  = '{"and",       4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 1'b0, 1'b0, 1};
      vecs[7]  = '{"or",        4'd6,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'h0, 1'b0, 1'b0, 1};
      vecs[8]  = '{"xor",       4'd7,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 1'b0, 1'b0, 1};
      vecs[9]  = '{"nor",       4'd8,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 32'h0, 1'b0, 1'b0, 1};
      vecs[10] = '{"slt",       4'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0, 1};
      vecs[11] = '{"sltu",      4'd10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b0, 1'b0, 1};
      vecs[12] = '{"reserved",  4'd15, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'h0, 1'b0, 1'b0, 1};
      vecs[13] = '{"mult_neg",  4'd11, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b0, 33};
      vecs[14] = '{"multu_max", 4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 33};
      vecs[15] = '{"mult_nn",   4'd11, 32'hFFFFFFFB, 32'hFFFFFFFC, 32'h00000014, 32'h00000000, 1'b0, 1'b0, 33};
      vecs[16] = '{"div_neg",   4'd13, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 33};
      vecs[17] = '{"div_min",   4'd13, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 33};
      vecs[18] = '{"divu_zero", 4'd14, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'h00000005, 1'b0, 1'b1, 33};
      vecs[19] = '{"divu",      4'd14, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 1'b0, 1'b0, 33};
      vecs[20] = '{"div_posneg",4'd13, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, 1'b0, 33};
      vecs[21] = '{"div_zero_s",4'd13, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFF8, 1'b0, 1'b1, 33};

      RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; port_a = '0; port_b = '0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready",  in_ready, 1);
      check("rst_lo",        result_lo, 0);
      check("rst_hi",        result_hi, 0);
      check("rst_flags",     {negative, zero, overflow, div_zero}, 4'b0100);

      for (int i = 0; i < 22; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b);
         check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
         check({vecs[i].name, "_lo"},  result_lo, vecs[i].lo);
         check({vecs[i].name, "_hi"},  result_hi, vecs[i].hi);
         check({vecs[i].name, "_ovf"}, overflow, vecs[i].ovf);
         check({vecs[i].name, "_dz"},  div_zero, vecs[i].dz);
         check({vecs[i].name, "_neg"}, negative, vecs[i].lo[31]);
         check({vecs[i].name, "_zero"}, zero, vecs[i].lo == 32'h0);
         check({vecs[i].name, "_busy_ready"}, rdy_bad, 0);
         release_out();
      end

      // Hold in DONE for 5 cycles with a competing request, then release.
      run_op(4'd3, 32'd2, 32'd3);
      in_valid = 1'b1; op = 4'd4; port_a = 32'd9; port_b = 32'd2;
      repeat (5) begin
         @(negedge CLK);
         check("hold_valid", out_valid, 1);
         check("hold_lo",    result_lo, 32'd5);
         check("hold_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge CLK); #1;
      out_ready = 1'b0;
      check("release_idle_ready", in_ready, 1);
      check("release_idle_valid", out_valid, 0);
      @(posedge CLK); #1;
      in_valid = 1'b0;
      @(negedge CLK);
      check("after_release_valid", out_valid, 1);
      check("after_release_lo",    result_lo, 32'd7);
      release_out();

      // Reset in the middle of a DIVU (count 10), with a nonzero prior result held.
      run_op(4'd14, 32'd100, 32'd7);
      check("divu100_lo", result_lo, 32'd14);
      check("divu100_hi", result_hi, 32'd2);
      release_out();
      @(negedge CLK);
      in_valid = 1'b1; op = 4'd14; port_a = 32'd1000; port_b = 32'd3;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge CLK);
      #1 RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      check("abort_valid", out_valid, 0);
      check("abort_ready", in_ready, 1);
      check("abort_lo",    result_lo, 0);
      check("abort_hi",    result_hi, 0);
      check("abort_flags", {negative, zero, overflow, div_zero}, 4'b0100);
      run_op(4'd3, 32'd2, 32'd3);
      check("post_abort_lat", lat, 1);
      check("post_abort_lo",  result_lo, 32'd5);
      check("post_abort_hi",  result_hi, 32'd0);
      check("post_abort_flags", {negative, zero, overflow, div_zero}, 4'b0000);
      release_out();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
